// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic-computer controller.
// Opcodes, FSM state encoding and register-reference bit positions.
package mano_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int RR_CLA = 3;
    localparam int RR_CMA = 2;
    localparam int RR_INC = 1;
    localparam int RR_HLT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_DECODE,
        ST_INDIR,
        ST_EXEC0,
        ST_EXEC1,
        ST_EXEC2,
        ST_HALT
    } state_e;

    // Memory-reference opcodes that load DR from memory in EXEC0.
    function automatic logic exec0_reads(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA) || (op == OP_ISZ);
    endfunction

endpackage

// File: rtl/mano_alu.sv
// Accumulator ALU: AND, ADD with carry into E, LDA pass-through and the CLA/CMA/INC chain.
// Purely combinational; E is only modified by ADD.
module mano_alu
    import mano_pkg::*;
(
    input  logic [2:0] op,
    input  logic       cla,
    input  logic       cma,
    input  logic       inc,
    input  logic [7:0] ac,
    input  logic [7:0] dr,
    input  logic       e,
    output logic [7:0] ac_res,
    output logic       e_res
);

    logic [7:0] t;

    always_comb begin
        ac_res = ac;
        e_res  = e;
        t      = ac;
        case (op)
            OP_AND: ac_res = ac & dr;
            OP_ADD: {e_res, ac_res} = {1'b0, ac} + {1'b0, dr};
            OP_LDA: ac_res = dr;
            OP_REG: begin
                t      = cla ? 8'h00 : ac;
                t      = cma ? ~t : t;
                ac_res = inc ? t + 8'd1 : t;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mano_control.sv
// Multi-cycle Mano basic-computer control unit with 16x8 external memory interface.
// Memory strobes, address and write data are registered so they only change at clock edges.
module mano_control
    import mano_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_ar,
    output logic [7:0] mem_wdata,
    output logic [3:0] pc_out,
    output logic [7:0] ac_out,
    output logic       e_out,
    output logic [7:0] ir_out,
    output logic       halted
);

    state_e     state_q, state_d;
    logic [3:0] pc_q, ar_q;
    logic [7:0] ir_q, ac_q, dr_q;
    logic       e_q;
    logic       mem_read_q, mem_write_q;
    logic [7:0] mem_wdata_q;
    logic       mem_read_d, mem_write_d;
    logic [7:0] mem_wdata_d;
    logic [2:0] op;
    logic       ind;
    logic [7:0] dr_inc;
    logic [7:0] alu_ac;
    logic       alu_e;

    assign op     = ir_q[6:4];
    assign ind    = ir_q[7];
    assign dr_inc = dr_q + 8'd1;

    mano_alu u_alu (
        .op     (op),
        .cla    (ir_q[RR_CLA]),
        .cma    (ir_q[RR_CMA]),
        .inc    (ir_q[RR_INC]),
        .ac     (ac_q),
        .dr     (dr_q),
        .e      (e_q),
        .ac_res (alu_ac),
        .e_res  (alu_e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH0;
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_DECODE;
            ST_DECODE: state_d = (ind && (op != OP_REG)) ? ST_INDIR : ST_EXEC0;
            ST_INDIR:  state_d = ST_EXEC0;
            ST_EXEC0: begin
                case (op)
                    OP_STA, OP_BUN: state_d = ST_FETCH0;
                    OP_REG:         state_d = (!ind && ir_q[RR_HLT]) ? ST_HALT : ST_FETCH0;
                    default:        state_d = ST_EXEC1;
                endcase
            end
            ST_EXEC1: state_d = (op == OP_ISZ) ? ST_EXEC2 : ST_FETCH0;
            ST_EXEC2: state_d = ST_FETCH0;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes are decided one cycle ahead from the next state so they can be registered.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            ST_FETCH1, ST_INDIR: mem_read_d = 1'b1;
            ST_EXEC0: begin
                mem_read_d = exec0_reads(op);
                if (op == OP_STA) begin
                    mem_write_d = 1'b1;
                    mem_wdata_d = ac_q;
                end else if (op == OP_BSA) begin
                    mem_write_d = 1'b1;
                    mem_wdata_d = {4'h0, pc_q};
                end
            end
            ST_EXEC2: begin
                mem_write_d = 1'b1;
                mem_wdata_d = dr_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= 8'h00;
        end else begin
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ar_q <= 4'h0;
            ir_q <= 8'h00;
            ac_q <= 8'h00;
            dr_q <= 8'h00;
            e_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH0: ar_q <= pc_q;
                ST_FETCH1: begin
                    ir_q <= mem_rdata;
                    pc_q <= pc_q + 4'd1;
                end
                ST_DECODE: ar_q <= ir_q[3:0];
                ST_INDIR:  ar_q <= mem_rdata[3:0];
                ST_EXEC0: begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: dr_q <= mem_rdata;
                        OP_BUN: pc_q <= ar_q;
                        OP_BSA: ar_q <= ar_q + 4'd1;
                        OP_REG: begin
                            if (!ind) begin
                                ac_q <= alu_ac;
                                e_q  <= alu_e;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_EXEC1: begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA: begin
                            ac_q <= alu_ac;
                            e_q  <= alu_e;
                        end
                        OP_BSA:  pc_q <= ar_q;
                        OP_ISZ:  dr_q <= dr_inc;
                        default: ;
                    endcase
                end
                ST_EXEC2: if (dr_q == 8'h00) pc_q <= pc_q + 4'd1;
                default: ;
            endcase
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ar    = ar_q;
    assign pc_out    = pc_q;
    assign ac_out    = ac_q;
    assign e_out     = e_q;
    assign ir_out    = ir_q;
    assign halted    = (state_q == ST_IDLE) || (state_q == ST_HALT);

endmodule
